cache_port_arb: RTL and testbench
=================================

Name: cache_port_arb

Overview:
- Two-requester arbiter sharing the single p0 request/response port of cache_ctrl between instruction fetch (m0) and data access (m1).
- Round-robin grant on the request channel with grant lock until handshake.
- In-order ID FIFO routes each p0 response back to the requester that issued it.
- Sits between the core's fetch/LSU front ends and the cache_ctrl p0 interface.

Parameters:
- ADDR_WIDTH, 30, word address width on all request channels.
- MAX_OUTSTANDING, 4, ID FIFO depth and maximum accepted-but-unanswered requests (power of 2, >=2).
- WRITE_RESP, 1, 1: writes (web=0) return one response beat; 0: writes return none and are not tracked.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous active-high reset
- m0_uvld_i / m1_uvld_i  in  1  requester n request valid
- m0_urdy_o / m1_urdy_o  out  1  requester n request ready
- m0_addr_i / m1_addr_i  in  ADDR_WIDTH  requester n word address
- m0_web_i / m1_web_i  in  1  requester n write enable, active low
- m0_wdat_i / m1_wdat_i  in  32  requester n write data
- m0_wmask_i / m1_wmask_i  in  4  requester n byte mask
- m0_dvld_o / m1_dvld_o  out  1  requester n response valid
- m0_drdy_i / m1_drdy_i  in  1  requester n response ready
- m_ddat_o  out  32  response data, shared by both requesters
- p0_uvld_o  out  1  downstream request valid
- p0_urdy_i  in  1  downstream request ready
- p0_addr_o  out  ADDR_WIDTH  downstream address
- p0_web_o  out  1  downstream write enable, active low
- p0_wdat_o  out  32  downstream write data
- p0_wmask_o  out  4  downstream byte mask
- p0_dvld_i  in  1  downstream response valid
- p0_drdy_o  out  1  downstream response ready
- p0_ddat_i  in  32  downstream response data

Behaviour:
- Single clock domain: clk. Synchronous active-high reset.
- Reset values:
  - FIFO empty, count=0.
  - rr_ptr=0 (m0 favoured).
  - lock=0.
  - All *_vld_o and *_urdy_o deassert combinationally once reset state is loaded.
- Grant selection, combinational:
  - If lock=1, grant = locked_id.
  - Else if only one uvld is high, grant that requester.
  - If both are high, grant rr_ptr.
- Request mux:
  - p0_addr/web/wdat/wmask_o = granted requester's fields.
  - p0_uvld_o = granted uvld AND NOT fifo_full.
- Ready:
  - granted m_urdy_o = p0_urdy_i AND NOT fifo_full.
  - Non-granted m_urdy_o = 0.
  - Zero-cycle pass-through; no request register.
- Accept = p0_uvld_o AND p0_urdy_i.
  - On accept: rr_ptr <= ~grant, lock <= 0.
  - Push grant ID unless WRITE_RESP=0 and web=0.
- Lock:
  - If p0_uvld_o=1 and p0_urdy_i=0, set lock<=1 and locked_id<=grant.
  - Grant must not switch while a request is presented unaccepted.
  - Requesters must hold uvld and fields stable until accepted.
- fifo_full = (count == MAX_OUTSTANDING).
  - Full blocks new accepts even if a pop occurs in the same cycle; no push-through when full.
- Response routing:
  - Head ID h selects the requester.
  - mh_dvld_o = p0_dvld_i AND NOT fifo_empty; the other requester's dvld_o = 0.
  - p0_drdy_o = mh_drdy_i AND NOT fifo_empty.
  - m_ddat_o = p0_ddat_i always.
  - Pop on p0_dvld_i AND p0_drdy_o.
- p0_dvld_i while FIFO empty is a protocol error:
  - p0_drdy_o = 0; no pop; no dvld to either requester.
  - Simulation assertion fires.
- Simultaneous push and pop (not full): count unchanged, head advances, tail advances.
- Pointers: log2(MAX_OUTSTANDING) bits, wrap modulo depth. Count has one extra bit.
- Reset mid-transaction:
  - FIFO, lock and rr_ptr are cleared.
  - Responses outstanding at reset are dropped, and downstream must also be reset.

Test Plan:
- Reset, then both uvld=1 held, p0_urdy=1 -> accepts alternate m0,m1,m0,m1. After 4 accepts with no responses, fifo_full and both urdy_o=0.
- m0 request at 0x100 with p0_urdy=0 for 3 cycles; m1 raises uvld in cycle 1 -> p0_addr_o stays 0x100. m0 is accepted in cycle 3, then m1 is granted.
- Issue m1 then m0 reads; p0 returns 0xAAAA0001 then 0xBBBB0002 -> m1_dvld with 0xAAAA0001 first, then m0_dvld with 0xBBBB0002.
- FIFO full (4 outstanding); pop and new request in the same cycle -> pop happens, no accept that cycle, accept next cycle, count returns to 4.
- Head requester holds drdy=0 for 2 cycles while p0_dvld=1 -> p0_drdy_o=0 during the stall; single pop when drdy=1.
- WRITE_RESP=0: m0 write (web=0) then m0 read -> only the read is tracked (count=1), and one m0 response is delivered.

Source files
------------

// File: rtl/cache_port_arb_if.sv
// Purpose : request/response channel bundle shared by the cache_port_arb
//           requester ports (m0, m1) and its downstream p0 port.
// Signals : uvld/urdy request handshake, addr/web/wdat/wmask request
//           payload, dvld/drdy response handshake, ddat response data.
// Modports: master = side that issues requests, slave = side that serves them.
interface cache_port_arb_if #(
  parameter int unsigned ADDR_WIDTH = 30
);
  logic                  uvld;
  logic                  urdy;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  web;
  logic [31:0]           wdat;
  logic [3:0]            wmask;
  logic                  dvld;
  logic                  drdy;
  logic [31:0]           ddat;

  modport master (
    output uvld, addr, web, wdat, wmask, drdy,
    input  urdy, dvld, ddat
  );

  modport slave (
    input  uvld, addr, web, wdat, wmask, drdy,
    output urdy, dvld, ddat
  );
endinterface

// File: rtl/cache_port_arb.sv
// Purpose : round-robin arbiter sharing the cache_ctrl p0 port between
//           instruction fetch (m0) and data access (m1). The grant is locked
//           while a request is presented but not yet accepted; an in-order
//           ID FIFO steers each p0 response back to the requester that
//           issued it.
// Ports   : clk, reset (synchronous, active high)
//           m0, m1 : requester channels (slave side of cache_port_arb_if)
//           p0     : downstream cache_ctrl channel (master side)
//           Response data on m0.ddat / m1.ddat is p0.ddat for both.
module cache_port_arb #(
  parameter int unsigned ADDR_WIDTH      = 30,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter bit          WRITE_RESP      = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  cache_port_arb_if.slave   m0,
  cache_port_arb_if.slave   m1,
  cache_port_arb_if.master  p0
);

  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic                       rr_ptr_q, rr_ptr_d;
  logic                       lock_q, lock_d;
  logic                       locked_id_q, locked_id_d;
  logic [MAX_OUTSTANDING-1:0] id_q, id_d;
  logic [PTR_W-1:0]           head_q, head_d;
  logic [PTR_W-1:0]           tail_q, tail_d;
  logic [CNT_W-1:0]           count_q, count_d;

  logic                  grant_c;
  logic                  gnt_uvld_c;
  logic                  gnt_web_c;
  logic [ADDR_WIDTH-1:0] gnt_addr_c;
  logic                  fifo_full_c;
  logic                  fifo_empty_c;
  logic                  head_id_c;
  logic                  head_drdy_c;
  logic                  p0_uvld_c;
  logic                  p0_drdy_c;
  logic                  accept_c;
  logic                  push_c;
  logic                  pop_c;

  // Grant: locked requester first, then the sole requester, else round-robin.
  always_comb begin
    grant_c = rr_ptr_q;
    if (lock_q) begin
      grant_c = locked_id_q;
    end else if (m0.uvld && !m1.uvld) begin
      grant_c = 1'b0;
    end else if (m1.uvld && !m0.uvld) begin
      grant_c = 1'b1;
    end
  end

  // FIFO status and handshake qualifiers.
  always_comb begin
    fifo_full_c  = (count_q == CNT_W'(MAX_OUTSTANDING));
    fifo_empty_c = (count_q == '0);
    gnt_uvld_c   = grant_c ? m1.uvld : m0.uvld;
    gnt_web_c    = grant_c ? m1.web  : m0.web;
    gnt_addr_c   = grant_c ? m1.addr : m0.addr;
    // A full FIFO blocks accepts even when a pop lands in the same cycle.
    p0_uvld_c    = gnt_uvld_c && !fifo_full_c;
    accept_c     = p0_uvld_c && p0.urdy;
    // Writes are untracked when the downstream sends no write response.
    push_c       = accept_c && (WRITE_RESP || gnt_web_c);
    head_id_c    = id_q[head_q];
    head_drdy_c  = head_id_c ? m1.drdy : m0.drdy;
    // An empty FIFO never acknowledges a stray response.
    p0_drdy_c    = head_drdy_c && !fifo_empty_c;
    pop_c        = p0.dvld && p0_drdy_c;
  end

  // Request mux and response routing (zero-cycle pass-through).
  always_comb begin
    p0.uvld  = p0_uvld_c;
    p0.addr  = gnt_addr_c;
    p0.web   = gnt_web_c;
    p0.wdat  = grant_c ? m1.wdat  : m0.wdat;
    p0.wmask = grant_c ? m1.wmask : m0.wmask;
    p0.drdy  = p0_drdy_c;
    m0.urdy  = !grant_c && m0.uvld && p0.urdy && !fifo_full_c;
    m1.urdy  =  grant_c && m1.uvld && p0.urdy && !fifo_full_c;
    m0.dvld  = p0.dvld && !fifo_empty_c && !head_id_c;
    m1.dvld  = p0.dvld && !fifo_empty_c &&  head_id_c;
    m0.ddat  = p0.ddat;
    m1.ddat  = p0.ddat;
  end

  // Next state: round-robin pointer, grant lock and ID FIFO.
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    lock_d      = lock_q;
    locked_id_d = locked_id_q;
    id_d        = id_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;

    if (accept_c) begin
      rr_ptr_d = ~grant_c;
      lock_d   = 1'b0;
    end else if (p0_uvld_c) begin
      lock_d      = 1'b1;
      locked_id_d = grant_c;
    end

    if (push_c) begin
      id_d[tail_q] = grant_c;
      tail_d       = tail_q + PTR_W'(1);
    end
    if (pop_c) begin
      head_d = head_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q    <= 1'b0;
      lock_q      <= 1'b0;
      locked_id_q <= 1'b0;
      id_q        <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      lock_q      <= lock_d;
      locked_id_q <= locked_id_d;
      id_q        <= id_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
    end
  end

  // A response with nothing outstanding is a downstream protocol error.
  a_no_orphan_resp: assert property (@(posedge clk) disable iff (reset)
    !(p0.dvld && fifo_empty_c));

endmodule

// File: tb/tb_cache_port_arb.sv
module tb_cache_port_arb;

  logic clk;
  logic reset;

  cache_port_arb_if #(.ADDR_WIDTH(30)) m0_if ();
  cache_port_arb_if #(.ADDR_WIDTH(30)) m1_if ();
  cache_port_arb_if #(.ADDR_WIDTH(30)) p0_if ();
  cache_port_arb_if #(.ADDR_WIDTH(30)) n0_if ();
  cache_port_arb_if #(.ADDR_WIDTH(30)) n1_if ();
  cache_port_arb_if #(.ADDR_WIDTH(30)) np_if ();

  cache_port_arb #(.ADDR_WIDTH(30), .MAX_OUTSTANDING(4), .WRITE_RESP(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .m0    (m0_if),
    .m1    (m1_if),
    .p0    (p0_if)
  );

  cache_port_arb #(.ADDR_WIDTH(30), .MAX_OUTSTANDING(4), .WRITE_RESP(1'b0)) dut_nw (
    .clk   (clk),
    .reset (reset),
    .m0    (n0_if),
    .m1    (n1_if),
    .p0    (np_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [29:0] A0 = 30'h100;
  localparam logic [29:0] A1 = 30'h200;
  localparam logic [31:0] WD0 = 32'h1111_1111;
  localparam logic [31:0] WD1 = 32'h2222_2222;
  localparam logic [3:0]  WM0 = 4'h3;
  localparam logic [3:0]  WM1 = 4'hC;

  typedef struct {
    logic        rst;
    logic        u0, u1, pu, dv, d0, d1;
    logic [31:0] dd;
    logic        eu0, eu1, epv;
    logic [29:0] ea;
    logic        ed0, ed1, epd;
  } vec_t;

  vec_t vq[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic vec_t mk(logic r, logic u0, logic u1, logic pu, logic dv,
                              logic d0, logic d1, logic [31:0] dd,
                              logic eu0, logic eu1, logic epv, logic [29:0] ea,
                              logic ed0, logic ed1, logic epd);
    vec_t v;
    v.rst = r;  v.u0 = u0;  v.u1 = u1;  v.pu = pu; v.dv = dv;
    v.d0 = d0;  v.d1 = d1;  v.dd = dd;
    v.eu0 = eu0; v.eu1 = eu1; v.epv = epv; v.ea = ea;
    v.ed0 = ed0; v.ed1 = ed1; v.epd = epd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    string tag;

    reset = 1'b1;
    m0_if.uvld = 0; m0_if.addr = A0; m0_if.web = 1; m0_if.wdat = WD0; m0_if.wmask = WM0; m0_if.drdy = 0;
    m1_if.uvld = 0; m1_if.addr = A1; m1_if.web = 1; m1_if.wdat = WD1; m1_if.wmask = WM1; m1_if.drdy = 0;
    p0_if.urdy = 0; p0_if.dvld = 0; p0_if.ddat = '0;
    n0_if.uvld = 0; n0_if.addr = A0; n0_if.web = 1; n0_if.wdat = WD0; n0_if.wmask = WM0; n0_if.drdy = 0;
    n1_if.uvld = 0; n1_if.addr = A1; n1_if.web = 1; n1_if.wdat = WD1; n1_if.wmask = WM1; n1_if.drdy = 0;
    np_if.urdy = 0; np_if.dvld = 0; np_if.ddat = '0;

    //        rst u0 u1 pu dv d0 d1 ddat           eu0 eu1 epv addr ed0 ed1 epd
    // Alternation with both requesting, fill to full, pop vs. new request.
    vq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 32'h0,         0, 0, 0, A0, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 1, 0, 0, 0, 32'h0,         0, 0, 0, A0, 0, 0, 0));
    vq.push_back(mk(0, 1, 1, 1, 0, 0, 0, 32'h0,         1, 0, 1, A0, 0, 0, 0));
    vq.push_back(mk(0, 1, 1, 1, 0, 0, 0, 32'h0,         0, 1, 1, A1, 0, 0, 0));
    vq.push_back(mk(0, 1, 1, 1, 0, 0, 0, 32'h0,         1, 0, 1, A0, 0, 0, 0));
    vq.push_back(mk(0, 1, 1, 1, 0, 0, 0, 32'h0,         0, 1, 1, A1, 0, 0, 0));
    vq.push_back(mk(0, 1, 1, 1, 0, 0, 0, 32'h0,         0, 0, 0, A0, 0, 0, 0));
    vq.push_back(mk(0, 1, 1, 1, 1, 1, 0, 32'hA5A5_0000, 0, 0, 0, A0, 1, 0, 1));
    vq.push_back(mk(0, 1, 1, 1, 0, 0, 0, 32'h0,         1, 0, 1, A0, 0, 0, 0));
    vq.push_back(mk(0, 1, 1, 1, 0, 0, 0, 32'h0,         0, 0, 0, A1, 0, 0, 0));
    // Head (m1) stalls drdy for two cycles, then drain in order 1,0,1,0.
    vq.push_back(mk(0, 0, 0, 0, 1, 1, 0, 32'hC000_0000, 0, 0, 0, A1, 0, 1, 0));
    vq.push_back(mk(0, 0, 0, 0, 1, 1, 0, 32'hC000_0000, 0, 0, 0, A1, 0, 1, 0));
    vq.push_back(mk(0, 0, 0, 0, 1, 1, 1, 32'hC000_0000, 0, 0, 0, A1, 0, 1, 1));
    vq.push_back(mk(0, 0, 0, 0, 1, 1, 1, 32'hC000_0001, 0, 0, 0, A1, 1, 0, 1));
    vq.push_back(mk(0, 0, 0, 0, 1, 0, 1, 32'hC000_0002, 0, 0, 0, A1, 0, 1, 1));
    vq.push_back(mk(0, 0, 0, 0, 1, 1, 0, 32'hC000_0003, 0, 0, 0, A1, 1, 0, 1));
    vq.push_back(mk(0, 0, 0, 1, 0, 0, 0, 32'h0,         0, 0, 0, A1, 0, 0, 0));
    // Grant lock: m0 stalled 3 cycles while m1 also requests.
    vq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 32'h0,         0, 0, 0, A0, 0, 0, 0));
    vq.push_back(mk(0, 1, 0, 0, 0, 0, 0, 32'h0,         0, 0, 1, A0, 0, 0, 0));
    vq.push_back(mk(0, 1, 1, 0, 0, 0, 0, 32'h0,         0, 0, 1, A0, 0, 0, 0));
    vq.push_back(mk(0, 1, 1, 0, 0, 0, 0, 32'h0,         0, 0, 1, A0, 0, 0, 0));
    vq.push_back(mk(0, 1, 1, 1, 0, 0, 0, 32'h0,         1, 0, 1, A0, 0, 0, 0));
    vq.push_back(mk(0, 0, 1, 1, 0, 0, 0, 32'h0,         0, 1, 1, A1, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 1, 0, 0, 0, 32'h0,         0, 0, 0, A0, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 1, 1, 0, 32'h0000_0001, 0, 0, 0, A0, 1, 0, 1));
    vq.push_back(mk(0, 0, 0, 0, 1, 0, 1, 32'h0000_0002, 0, 0, 0, A0, 0, 1, 1));
    // m1 then m0 reads; responses routed back in issue order.
    vq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 32'h0,         0, 0, 0, A0, 0, 0, 0));
    vq.push_back(mk(0, 0, 1, 1, 0, 0, 0, 32'h0,         0, 1, 1, A1, 0, 0, 0));
    vq.push_back(mk(0, 1, 0, 1, 0, 0, 0, 32'h0,         1, 0, 1, A0, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 1, 1, 1, 32'hAAAA_0001, 0, 0, 0, A1, 0, 1, 1));
    vq.push_back(mk(0, 0, 0, 0, 1, 1, 1, 32'hBBBB_0002, 0, 0, 0, A1, 1, 0, 1));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'h0,         0, 0, 0, A1, 0, 0, 0));

    for (int i = 0; i < vq.size(); i++) begin
      v = vq[i];
      reset      = v.rst;
      m0_if.uvld = v.u0;  m1_if.uvld = v.u1;
      m0_if.drdy = v.d0;  m1_if.drdy = v.d1;
      p0_if.urdy = v.pu;  p0_if.dvld = v.dv;  p0_if.ddat = v.dd;
      #1;
      if (!v.rst) begin
        tag = $sformatf("v%0d", i);
        chk({tag, "_m0_urdy"}, 32'(m0_if.urdy), 32'(v.eu0));
        chk({tag, "_m1_urdy"}, 32'(m1_if.urdy), 32'(v.eu1));
        chk({tag, "_p0_uvld"}, 32'(p0_if.uvld), 32'(v.epv));
        chk({tag, "_p0_addr"}, 32'(p0_if.addr), 32'(v.ea));
        chk({tag, "_p0_wdat"}, p0_if.wdat, (v.ea == A0) ? WD0 : WD1);
        chk({tag, "_p0_wmask"}, 32'(p0_if.wmask), 32'((v.ea == A0) ? WM0 : WM1));
        chk({tag, "_m0_dvld"}, 32'(m0_if.dvld), 32'(v.ed0));
        chk({tag, "_m1_dvld"}, 32'(m1_if.dvld), 32'(v.ed1));
        chk({tag, "_p0_drdy"}, 32'(p0_if.drdy), 32'(v.epd));
        chk({tag, "_m0_ddat"}, m0_if.ddat, v.dd);
        chk({tag, "_m1_ddat"}, m1_if.ddat, v.dd);
      end
      @(posedge clk); #1;
    end

    // Untracked writes on the WRITE_RESP=0 instance.
    m0_if.uvld = 0; m1_if.uvld = 0; p0_if.urdy = 0; p0_if.dvld = 0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("nw_reset_count", 32'(dut_nw.count_q), 32'd0);

    n0_if.uvld = 1; n0_if.web = 0; np_if.urdy = 1;
    #1;
    chk("nw_write_p0_uvld", 32'(np_if.uvld), 32'd1);
    chk("nw_write_p0_web",  32'(np_if.web),  32'd0);
    chk("nw_write_m0_urdy", 32'(n0_if.urdy), 32'd1);
    @(posedge clk); #1;
    chk("nw_count_after_write", 32'(dut_nw.count_q), 32'd0);

    n0_if.web = 1;
    #1;
    chk("nw_read_p0_web", 32'(np_if.web), 32'd1);
    @(posedge clk); #1;
    chk("nw_count_after_read", 32'(dut_nw.count_q), 32'd1);

    n0_if.uvld = 0; np_if.urdy = 0;
    np_if.dvld = 1; np_if.ddat = 32'hD00D_0042; n0_if.drdy = 1;
    #1;
    chk("nw_resp_m0_dvld", 32'(n0_if.dvld), 32'd1);
    chk("nw_resp_m1_dvld", 32'(n1_if.dvld), 32'd0);
    chk("nw_resp_p0_drdy", 32'(np_if.drdy), 32'd1);
    chk("nw_resp_ddat",    n0_if.ddat,      32'hD00D_0042);
    @(posedge clk); #1;
    np_if.dvld = 0; n0_if.drdy = 0;
    #1;
    chk("nw_count_after_resp", 32'(dut_nw.count_q), 32'd0);
    chk("nw_idle_m0_dvld",     32'(n0_if.dvld),     32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
